// File: rtl/mem_readout_sched_if.sv
// Purpose: bus bundle between the per-BX readout scheduler and its driver/mux.
// Latency: n/a (wiring only).
// Backpressure: none; start is a pulse and the scheduler never stalls.
//
// Ports carried:
//   start      driver -> sched  one-cycle pulse, new BX begins
//   BX         driver -> sched  BX number, sampled with start
//   n_entries  driver -> sched  12 packed per-port entry counts (ADDR_W+1 bits each)
//   read_en    sched  -> mems   one-hot read enable
//   read_add   sched  -> mems   shared read address
//   sel        sched  -> mux    binary mux select, aligned with read data
//   bx_out     sched  -> mux    latched BX
//   busy/done/truncated         frame status
interface mem_readout_sched_if #(
    parameter int ADDR_W = 6
);
    logic                       start;
    logic [2:0]                 BX;
    logic [12*(ADDR_W+1)-1:0]   n_entries;
    logic [11:0]                read_en;
    logic [ADDR_W-1:0]          read_add;
    logic [3:0]                 sel;
    logic [2:0]                 bx_out;
    logic                       busy;
    logic                       done;
    logic                       truncated;

    modport master (
        output start, BX, n_entries,
        input  read_en, read_add, sel, bx_out, busy, done, truncated
    );

    modport slave (
        input  start, BX, n_entries,
        output read_en, read_add, sel, bx_out, busy, done, truncated
    );
endinterface

// File: rtl/mem_readout_sched.sv
// Purpose: per-BX readout scheduler: header slot, then reads every stored entry of 12 memories.
// Latency: header in the cycle after start; sel trails each read by MEM_LAT cycles.
// Backpressure: none; a start while busy aborts the frame, CYCLE_BUDGET caps slots per BX.
//
// Ports: clk, reset (sync, active high); bus (slave modport of mem_readout_sched_if).
// Optional macro SCHED_ROUND_ROBIN_EN: rotate one read per port per turn instead of
// draining the lowest-index port first.
module mem_readout_sched #(
    parameter int ADDR_W       = 6,
    parameter int CYCLE_BUDGET = 100,
    parameter int MEM_LAT      = 1
) (
    input  logic                clk,
    input  logic                reset,
    mem_readout_sched_if.slave  bus
);
    localparam int NP     = 12;
    localparam int CW     = ADDR_W + 1;
    localparam int SLOT_W = $clog2(CYCLE_BUDGET + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_READ   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    localparam logic [3:0] SEL_HEADER = 4'd15;

    logic [1:0]        state;
    logic [CW-1:0]     remaining [NP];
    logic [ADDR_W-1:0] addr      [NP];
    logic [SLOT_W-1:0] slots;
    logic [1:0]        lat_cnt;
    logic [3:0]        sel_pipe  [MEM_LAT];
    logic [2:0]        bx_q;
    logic              done_q;
    logic              trunc_q;

    logic [3:0]        base;
    logic [4:0]        sum;
    logic [3:0]        idx;
    logic [3:0]        pick;
    logic              pick_vld;
    logic              more_left;
    logic              any_pend;
    logic              issue;
    logic              budget_hit;

`ifdef SCHED_ROUND_ROBIN_EN
    logic [3:0]        rr_ptr;
`endif

    // Ports 9..11 skip code 10 so the mux table keeps 10 and 14 unused.
    function automatic logic [3:0] port_code(input logic [3:0] p);
        return (p < 4'd9) ? p + 4'd1 : p + 4'd2;
    endfunction

    // Port selection: first port with entries left, scanning from base.
    // Strict mode always scans from 0; round-robin scans from the port after the last read.
    always_comb begin
        pick_vld  = 1'b0;
        pick      = '0;
        sum       = '0;
        idx       = '0;
        more_left = 1'b0;
        any_pend  = 1'b0;
`ifdef SCHED_ROUND_ROBIN_EN
        base      = rr_ptr;
`else
        base      = 4'd0;
`endif
        for (int k = 0; k < NP; k++) begin
            sum = {1'b0, base} + 5'(k);
            idx = (sum >= 5'(NP)) ? 4'(sum - 5'(NP)) : sum[3:0];
            if (!pick_vld && remaining[idx] != '0) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
        // Whether anything is left once the current read is accounted for.
        for (int i = 0; i < NP; i++) begin
            any_pend = any_pend | (remaining[i] != '0);
            if (4'(i) == pick)
                more_left = more_left | (remaining[i] > CW'(1));
            else
                more_left = more_left | (remaining[i] != '0);
        end
    end

    assign issue      = (state == S_READ) && pick_vld;
    // slots already includes the header, so this read uses the last allowed slot.
    assign budget_hit = (slots == SLOT_W'(CYCLE_BUDGET - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            slots   <= '0;
            lat_cnt <= '0;
            bx_q    <= '0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
            for (int i = 0; i < NP; i++) begin
                remaining[i] <= '0;
                addr[i]      <= '0;
            end
            for (int i = 0; i < MEM_LAT; i++) sel_pipe[i] <= '0;
`ifdef SCHED_ROUND_ROBIN_EN
            rr_ptr  <= '0;
`endif
        end else begin
            done_q      <= 1'b0;
            sel_pipe[0] <= issue ? port_code(pick) : 4'd0;
            for (int i = 1; i < MEM_LAT; i++) sel_pipe[i] <= sel_pipe[i-1];

            if (bus.start) begin
                // New BX (or abort of the running one): flush in-flight sels, no done.
                state   <= S_HEADER;
                bx_q    <= bus.BX;
                slots   <= SLOT_W'(1);
                lat_cnt <= '0;
                trunc_q <= 1'b0;
                for (int i = 0; i < NP; i++) begin
                    remaining[i] <= bus.n_entries[i*CW +: CW];
                    addr[i]      <= '0;
                end
                for (int i = 0; i < MEM_LAT; i++) sel_pipe[i] <= '0;
`ifdef SCHED_ROUND_ROBIN_EN
                rr_ptr  <= '0;
`endif
            end else begin
                case (state)
                    S_HEADER: begin
                        lat_cnt <= '0;
                        state   <= any_pend ? S_READ : S_DRAIN;
                    end
                    S_READ: begin
                        if (issue) begin
                            remaining[pick] <= remaining[pick] - CW'(1);
                            addr[pick]      <= addr[pick] + ADDR_W'(1);
                            slots           <= slots + SLOT_W'(1);
`ifdef SCHED_ROUND_ROBIN_EN
                            rr_ptr          <= (pick == 4'(NP - 1)) ? 4'd0 : pick + 4'd1;
`endif
                            if (!more_left) begin
                                state <= S_DRAIN;
                            end else if (budget_hit) begin
                                state   <= S_DRAIN;
                                trunc_q <= 1'b1;
                            end
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        // Hold until the last read's sel has left the delay line.
                        if (lat_cnt == 2'(MEM_LAT - 1)) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.read_en   = issue ? (12'd1 << pick) : 12'd0;
    assign bus.read_add  = issue ? addr[pick] : '0;
    // Header code bypasses the delay line; everything else arrives with the data.
    assign bus.sel       = (state == S_HEADER) ? SEL_HEADER : sel_pipe[MEM_LAT-1];
    assign bus.bx_out    = bx_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.truncated = trunc_q;
endmodule

// File: tb/tb_mem_readout_sched.sv
// Purpose: self-checking bench for mem_readout_sched, two builds (MEM_LAT 1/budget 100, MEM_LAT 2/budget 20).
// Latency: expected traces are derived per frame from the read list and the cycle after start.
// Backpressure: n/a; frames may be aborted by a new start or by reset.
module tb_mem_readout_sched;
    localparam int AW   = 6;
    localparam int CW   = AW + 1;
    localparam int MAXR = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        bx;
    logic [12*CW-1:0]  n_ent;

    always #5 clk = ~clk;

    mem_readout_sched_if #(.ADDR_W(AW)) bus0 ();
    mem_readout_sched_if #(.ADDR_W(AW)) bus1 ();

    assign bus0.start     = start;
    assign bus0.BX        = bx;
    assign bus0.n_entries = n_ent;
    assign bus1.start     = start;
    assign bus1.BX        = bx;
    assign bus1.n_entries = n_ent;

    mem_readout_sched #(.ADDR_W(AW), .CYCLE_BUDGET(100), .MEM_LAT(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_readout_sched #(.ADDR_W(AW), .CYCLE_BUDGET(20), .MEM_LAT(2)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    int lat      [2]  = '{1, 2};
    int bud      [2]  = '{100, 20};
    int code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13};

    int       cnt      [12];
    int       rd_port  [2][MAXR];
    int       rd_addr  [2][MAXR];
    int       n_rd     [2];
    bit       tr       [2];
    bit       in_frame [2];
    int       fc       [2];
    logic [2:0] exp_bx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: list the reads a frame should make, in order, from the counts.
    function automatic void plan(input int d);
        int rem [12];
        int n;
        int p;
`ifdef SCHED_ROUND_ROBIN_EN
        int ptr;
        ptr = 0;
`endif
        n = 0;
        for (int i = 0; i < 12; i++) rem[i] = cnt[i];
        while (n < bud[d] - 1) begin
            p = -1;
`ifdef SCHED_ROUND_ROBIN_EN
            for (int k = 0; k < 12; k++)
                if (p < 0 && rem[(ptr + k) % 12] > 0) p = (ptr + k) % 12;
`else
            for (int k = 0; k < 12; k++)
                if (p < 0 && rem[k] > 0) p = k;
`endif
            if (p < 0) break;
            rd_port[d][n] = p;
            rd_addr[d][n] = cnt[p] - rem[p];
            rem[p]--;
            n++;
`ifdef SCHED_ROUND_ROBIN_EN
            ptr = (p + 1) % 12;
`endif
        end
        n_rd[d] = n;
        tr[d]   = 1'b0;
        for (int i = 0; i < 12; i++) if (rem[i] > 0) tr[d] = 1'b1;
    endfunction

    // Frame timeline relative to the header cycle f=0: reads at 1..N,
    // sel of read k at k+L, done at N+L+1.
    task automatic check_dut(input int d, input logic [11:0] re, input logic [AW-1:0] ra,
                             input logic [3:0] sl, input logic [2:0] bo, input logic bs,
                             input logic dn, input logic tro);
        int f, n, l;
        int e_re, e_ra, e_sl, e_bs, e_dn, e_tr;
        f = fc[d]; n = n_rd[d]; l = lat[d];
        e_re = 0; e_ra = 0; e_sl = 0; e_bs = 0; e_dn = 0;
        e_tr = tr[d] ? 1 : 0;
        if (in_frame[d]) begin
            if (f == 0) e_sl = 15;
            else if (f - l >= 1 && f - l <= n) e_sl = code_tab[rd_port[d][f-l-1]];
            if (f >= 1 && f <= n) begin
                e_re = 1 << rd_port[d][f-1];
                e_ra = rd_addr[d][f-1];
            end
            e_bs = (f <= n + l) ? 1 : 0;
            e_dn = (f == n + l + 1) ? 1 : 0;
            if (f <= n) e_tr = 0;
        end
        chk($sformatf("dut%0d f%0d read_en", d, f),   32'(re),  32'(e_re));
        chk($sformatf("dut%0d f%0d read_add", d, f),  32'(ra),  32'(e_ra));
        chk($sformatf("dut%0d f%0d sel", d, f),       32'(sl),  32'(e_sl));
        chk($sformatf("dut%0d f%0d bx_out", d, f),    32'(bo),  32'(exp_bx));
        chk($sformatf("dut%0d f%0d busy", d, f),      32'(bs),  32'(e_bs));
        chk($sformatf("dut%0d f%0d done", d, f),      32'(dn),  32'(e_dn));
        chk($sformatf("dut%0d f%0d truncated", d, f), 32'(tro), 32'(e_tr));
    endtask

    // One clock: drive inputs, advance the reference at the edge, check after it.
    task automatic step(input bit s, input bit r);
        start = s;
        reset = r;
        @(posedge clk);
        if (r) begin
            exp_bx = '0;
            for (int d = 0; d < 2; d++) begin
                in_frame[d] = 1'b0;
                tr[d]       = 1'b0;
            end
        end else if (s) begin
            exp_bx = bx;
            for (int d = 0; d < 2; d++) begin
                plan(d);
                in_frame[d] = 1'b1;
                fc[d]       = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (in_frame[d]) begin
                    fc[d]++;
                    if (fc[d] > n_rd[d] + lat[d] + 1) in_frame[d] = 1'b0;
                end
            end
        end
        #1;
        check_dut(0, bus0.read_en, bus0.read_add, bus0.sel, bus0.bx_out,
                  bus0.busy, bus0.done, bus0.truncated);
        check_dut(1, bus1.read_en, bus1.read_add, bus1.sel, bus1.bx_out,
                  bus1.busy, bus1.done, bus1.truncated);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 12; i++) cnt[i] = 0;
    endtask

    task automatic pack_counts();
        for (int i = 0; i < 12; i++) n_ent[i*CW +: CW] = CW'(cnt[i]);
    endtask

    // Start a frame and step until both builds finish, or stop early to abort.
    task automatic run_frame(input logic [2:0] b, input int abort_at);
        bx = b;
        pack_counts();
        step(1'b1, 1'b0);
        for (int c = 1; c < 400; c++) begin
            if (!in_frame[0] && !in_frame[1]) break;
            if (abort_at > 0 && c >= abort_at) break;
            step(1'b0, 1'b0);
        end
    endtask

    task automatic rand_counts();
        int mode;
        clear_counts();
        mode = int'($urandom_range(0, 3));
        case (mode)
            0: for (int i = 0; i < 12; i++)
                   cnt[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : 0;
            1: cnt[$urandom_range(0, 11)] = int'($urandom_range(0, 64));
            2: for (int i = 0; i < 12; i++) cnt[i] = int'($urandom_range(0, 15));
            default: repeat (3) cnt[$urandom_range(0, 11)] = int'($urandom_range(1, 8));
        endcase
    endtask

    initial begin
        int abort_at;
        reset  = 1'b1;
        start  = 1'b0;
        bx     = '0;
        n_ent  = '0;
        exp_bx = '0;
        for (int d = 0; d < 2; d++) begin
            in_frame[d] = 1'b0; tr[d] = 1'b0; fc[d] = 0; n_rd[d] = 0;
        end
        clear_counts();

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        clear_counts(); cnt[0] = 2; cnt[9] = 1;   run_frame(3'd5, 0);
        clear_counts();                           run_frame(3'd3, 0);
        for (int i = 0; i < 12; i++) cnt[i] = 10; run_frame(3'd1, 0);
        clear_counts(); cnt[3] = 3;               run_frame(3'd2, 0);
        clear_counts(); cnt[0] = 2; cnt[1] = 2;   run_frame(3'd4, 0);
        clear_counts(); cnt[5] = 64;              run_frame(3'd7, 0);
        clear_counts(); cnt[0] = 64; cnt[11] = 64; run_frame(3'd0, 0);

        // Abort 4 cycles in with a new BX.
        clear_counts(); cnt[2] = 5; cnt[7] = 4;   run_frame(3'd2, 4);
        clear_counts(); cnt[1] = 1;               run_frame(3'd6, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 12; i++) cnt[i] = 3;  run_frame(3'd1, 6);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Start and reset together: reset wins.
        clear_counts(); cnt[4] = 2; bx = 3'd5; pack_counts();
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        for (int fr = 0; fr < 60; fr++) begin
            rand_counts();
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
            run_frame(3'($urandom_range(0, 7)), abort_at);
        end
        step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
